// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared ALU, the unified
// memory port and the register file, with a memory-ready watchdog and an instret counter.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             bcond,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_source,
   output logic             alu_out_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic [2:0]       state,
   output logic             is_halted,
   output logic             trap,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5,
      S_TRAP = 3'd6
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_ECALL = 7'b1110011;

   localparam int unsigned WD_W = $clog2(MEM_TIMEOUT + 2);

   state_t          cur, nxt;
   logic [WD_W-1:0] wd;
   logic            wait_mem, timeout, retire, legal;
   logic            req, we, iord, irw, pcw, pcs, aow, rw;
   logic [1:0]      a_sel, b_sel, op_sel, wbs;

   assign wait_mem = (cur == S_IF || cur == S_MEM) && !mem_ready;
   assign timeout  = wait_mem && (MEM_TIMEOUT != 0) && (wd == WD_W'(MEM_TIMEOUT - 1));

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
         default:                           legal = 1'b0;
      endcase
      // branch funct3 010/011 are unassigned encodings
      if (opcode == OP_BR && funct3[2:1] == 2'b01)
         legal = 1'b0;
   end

   always_comb begin
      nxt    = cur;
      retire = 1'b0;
      req    = 1'b0;
      we     = 1'b0;
      iord   = 1'b0;
      irw    = 1'b0;
      pcw    = 1'b0;
      pcs    = 1'b0;
      aow    = 1'b0;
      rw     = 1'b0;
      a_sel  = 2'b00;
      b_sel  = 2'b00;
      op_sel = 2'b00;
      wbs    = 2'b00;
      case (cur)
         S_IF: begin
            req   = 1'b1;
            b_sel = 2'b10;
            if (mem_ready) begin
               irw = 1'b1;
               pcw = 1'b1;
               nxt = S_ID;
            end
         end
         S_ID: begin
            b_sel = 2'b01;
            aow   = 1'b1;
            if (opcode == OP_ECALL) nxt = S_HALT;
            else if (legal)         nxt = S_EX;
            else                    nxt = S_TRAP;
         end
         S_EX: begin
            case (opcode)
               OP_R: begin
                  a_sel = 2'b01; op_sel = 2'b10; aow = 1'b1; nxt = S_WB;
               end
               OP_I: begin
                  a_sel = 2'b01; b_sel = 2'b01; op_sel = 2'b11; aow = 1'b1; nxt = S_WB;
               end
               OP_LOAD, OP_STORE: begin
                  a_sel = 2'b01; b_sel = 2'b01; aow = 1'b1; nxt = S_MEM;
               end
               OP_BR: begin
                  a_sel = 2'b01; op_sel = 2'b01; pcs = 1'b1; pcw = bcond;
                  nxt = S_IF; retire = 1'b1;
               end
               OP_JAL: begin
                  pcw = 1'b1; pcs = 1'b1; nxt = S_WB;
               end
               OP_JALR: begin
                  a_sel = 2'b01; b_sel = 2'b01; pcw = 1'b1; nxt = S_WB;
               end
               OP_LUI: begin
                  a_sel = 2'b10; b_sel = 2'b01; aow = 1'b1; nxt = S_WB;
               end
               OP_AUIPC: begin
                  b_sel = 2'b01; aow = 1'b1; nxt = S_WB;
               end
               default: nxt = S_TRAP;
            endcase
         end
         S_MEM: begin
            req  = 1'b1;
            iord = 1'b1;
            we   = (opcode == OP_STORE);
            if (mem_ready) begin
               if (opcode == OP_STORE) begin
                  nxt    = S_IF;
                  retire = 1'b1;
               end else begin
                  nxt = S_WB;
               end
            end
         end
         S_WB: begin
            rw     = 1'b1;
            nxt    = S_IF;
            retire = 1'b1;
            if (opcode == OP_LOAD)                         wbs = 2'b01;
            else if (opcode == OP_JAL || opcode == OP_JALR) wbs = 2'b10;
         end
         default: nxt = cur;
      endcase
      if (timeout)
         nxt = S_TRAP;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cur       <= S_IF;
         wd        <= '0;
         instret   <= '0;
         is_halted <= 1'b0;
         trap      <= 1'b0;
      end else begin
         cur <= nxt;
         wd  <= (wait_mem && MEM_TIMEOUT != 0) ? wd + WD_W'(1) : '0;
         if (retire)
            instret <= instret + CNT_W'(1);
         if (nxt == S_HALT)
            is_halted <= 1'b1;
         if (nxt == S_TRAP)
            trap <= 1'b1;
      end
   end

   // Strobes respond to reset_n combinationally so an aborted access is dropped at once.
   assign mem_req       = req & reset_n;
   assign mem_we        = we & reset_n;
   assign ir_write      = irw & reset_n;
   assign pc_write      = pcw & reset_n;
   assign reg_write     = rw & reset_n;
   assign alu_out_write = aow & reset_n;
   assign i_or_d        = iord;
   assign pc_source     = pcs;
   assign alu_src_a     = a_sel;
   assign alu_src_b     = b_sel;
   assign alu_op        = op_sel;
   assign wb_sel        = wbs;
   assign state         = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed sequences with literal expectations, then random
// instruction streams checked every cycle against a table-driven reference model.
module tb_multicycle_control;

   localparam int unsigned TO = 4;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          reset_n, bcond, mem_ready;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic          mem_req, mem_we, i_or_d, ir_write, pc_write, pc_source, alu_out_write, reg_write;
   logic [1:0]    alu_src_a, alu_src_b, alu_op, wb_sel;
   logic [2:0]    state;
   logic          is_halted, trap;
   logic [CW-1:0] instret;

   multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3), .bcond(bcond),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
      .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
      .alu_out_write(alu_out_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .state(state),
      .is_halted(is_halted), .trap(trap), .instret(instret)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;
   bit chk_en = 1'b0;

   // Instruction classes 0..8 in table order; 9 = ecall; 10 = unsupported.
   logic [6:0] optab[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
   int ex_a[9]    = '{1, 1, 1, 1, 1, 0, 1, 2, 0};
   int ex_b[9]    = '{0, 1, 1, 1, 0, 0, 1, 1, 1};
   int ex_op[9]   = '{2, 3, 0, 0, 1, 0, 0, 0, 0};
   int ex_aow[9]  = '{1, 1, 1, 1, 0, 0, 0, 1, 1};
   int ex_next[9] = '{4, 4, 3, 3, 0, 4, 4, 4, 4};
   int wb_tab[9]  = '{0, 0, 1, 0, 0, 2, 2, 0, 0};

   function automatic int cls(input logic [6:0] opc);
      for (int i = 0; i < 9; i++)
         if (optab[i] == opc) return i;
      return (opc == 7'b1110011) ? 9 : 10;
   endfunction

   // Reference model state: state number, unready-cycle run, retire count, sticky flags.
   int ms = 0, mwd = 0, mret = 0;
   bit mhalt = 0, mtrap = 0;

   always @(posedge clk) begin
      int c, nms;
      bit ret, legal;
      if (!reset_n) begin
         ms = 0; mwd = 0; mret = 0; mhalt = 0; mtrap = 0;
      end else begin
         c = cls(opcode);
         nms = ms;
         ret = 0;
         legal = (c < 9) && !(c == 4 && (funct3 == 3'd2 || funct3 == 3'd3));
         case (ms)
            0: if (mem_ready) nms = 1;
            1: nms = (c == 9) ? 5 : (legal ? 2 : 6);
            2: begin nms = (c < 9) ? ex_next[c] : 6; ret = (c == 4); end
            3: if (mem_ready) begin nms = (c == 3) ? 0 : 4; ret = (c == 3); end
            4: begin nms = 0; ret = 1; end
            default: nms = ms;
         endcase
         if ((ms == 0 || ms == 3) && !mem_ready) begin
            mwd++;
            if (TO != 0 && mwd >= TO) nms = 6;
         end else begin
            mwd = 0;
         end
         if (ret) mret = (mret + 1) % (1 << CW);
         if (nms == 5) mhalt = 1;
         if (nms == 6) mtrap = 1;
         ms = nms;
      end
   end

   task automatic expected(output logic [24:0] v);
      int c, a, b, op, wbs;
      bit req, we, iord, irw, pcw, pcs, aow, rw;
      c = cls(opcode);
      {req, we, iord, irw, pcw, pcs, aow, rw} = '0;
      a = 0; b = 0; op = 0; wbs = 0;
      case (ms)
         0: begin req = 1; b = 2; if (mem_ready) begin irw = 1; pcw = 1; end end
         1: begin b = 1; aow = 1; end
         2: if (c < 9) begin
               a = ex_a[c]; b = ex_b[c]; op = ex_op[c]; aow = ex_aow[c] != 0;
               pcw = (c == 4) ? bcond : (c == 5 || c == 6);
               pcs = (c == 4 || c == 5);
            end
         3: begin req = 1; iord = 1; we = (c == 3); end
         4: begin rw = 1; if (c < 9) wbs = wb_tab[c]; end
         default: ;
      endcase
      if (!reset_n) {req, we, irw, pcw, rw, aow} = '0;
      v = {3'(ms), req, we, iord, irw, pcw, pcs, aow, 2'(a), 2'(b), 2'(op), rw, 2'(wbs),
           mhalt, mtrap, 4'(mret)};
   endtask

   always @(negedge clk) begin
      logic [24:0] e, act;
      #2;
      if (chk_en) begin
         expected(e);
         act = {state, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_source, alu_out_write,
                alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, is_halted, trap, instret};
         compared++;
         if (act !== e) begin
            mismatched++;
            $display("FAIL cycle_outputs t=%0t opcode=%b rdy=%b actual=%h expected=%h",
                     $time, opcode, mem_ready, act, e);
         end
      end
   end

   task automatic lit(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
      end
   endtask

   logic [6:0] cur_op = 7'b0110011;
   logic [2:0] cur_f3 = 3'd0;

   task automatic cyc(input logic rn, input logic rdy, input logic bc);
      @(negedge clk);
      reset_n = rn; mem_ready = rdy; bcond = bc; opcode = cur_op; funct3 = cur_f3;
      #3;
   endtask

   initial begin
      int stuck;
      logic rn, rdy;
      reset_n = 1'b0; mem_ready = 1'b0; bcond = 1'b0; opcode = cur_op; funct3 = '0;
      cyc(0, 0, 0);
      chk_en = 1'b1;
      cyc(0, 0, 0);
      lit("reset_state", state, 0); lit("reset_instret", instret, 0); lit("reset_req", mem_req, 0);

      // R-type, memory always ready
      cur_op = 7'b0110011;
      cyc(1, 1, 0); lit("r_if", state, 0); lit("r_irw", ir_write, 1);
      cyc(1, 1, 0); lit("r_id", state, 1);
      cyc(1, 1, 0); lit("r_ex", state, 2); lit("r_aluop", alu_op, 2);
      cyc(1, 1, 0); lit("r_wb", state, 4); lit("r_regw", reg_write, 1);
      cur_op = 7'b0000011;
      cyc(1, 0, 0); lit("r_done_state", state, 0); lit("r_done_instret", instret, 1);

      // load: 3 wait cycles in IF, 2 in MEM
      cyc(1, 0, 0);
      cyc(1, 0, 0); lit("ld_if_req", mem_req, 1); lit("ld_if_irw", ir_write, 0);
      cyc(1, 1, 0); lit("ld_if_rdy_irw", ir_write, 1);
      cyc(1, 0, 0); lit("ld_id", state, 1);
      cyc(1, 0, 0); lit("ld_ex", state, 2);
      cyc(1, 0, 0); lit("ld_mem", state, 3); lit("ld_iord", i_or_d, 1); lit("ld_we", mem_we, 0);
      cyc(1, 0, 0);
      cyc(1, 1, 0); lit("ld_mem_rdy", state, 3);
      cyc(1, 0, 0); lit("ld_wb", state, 4); lit("ld_wbsel", wb_sel, 1);

      // branches taken / not taken
      cur_op = 7'b1100011;
      cyc(1, 1, 0); lit("br_instret0", instret, 2);
      cyc(1, 0, 0);
      cyc(1, 0, 1); lit("br_t_pcw", pc_write, 1); lit("br_t_pcs", pc_source, 1);
      lit("br_t_aow", alu_out_write, 0);
      cyc(1, 1, 0); lit("br_t_ret", instret, 3); lit("br_t_if", state, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0); lit("br_n_pcw", pc_write, 0); lit("br_n_pcs", pc_source, 1);
      cur_op = 7'b1110011;
      cyc(1, 1, 0); lit("br_n_ret", instret, 4);

      // ecall halts
      cyc(1, 1, 0); lit("ec_id", state, 1);
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, 0);
         lit("ec_halt", state, 5); lit("ec_flag", is_halted, 1);
         lit("ec_req", mem_req, 0); lit("ec_instret", instret, 4);
      end
      cyc(0, 1, 0); lit("ec_rst_req", mem_req, 0);

      // reserved branch funct3 traps at ID
      cur_op = 7'b1100011; cur_f3 = 3'd2;
      cyc(1, 1, 0); lit("il_if", state, 0); lit("il_instret", instret, 0);
      lit("il_halt_clr", is_halted, 0);
      cyc(1, 1, 0);
      cyc(1, 0, 0); lit("il_trap_state", state, 6); lit("il_trap", trap, 1);
      cyc(0, 0, 0);

      // watchdog: four unready MEM cycles trap
      cur_op = 7'b0000011; cur_f3 = 3'd0;
      cyc(1, 1, 0); lit("wd_trap_clr", trap, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0); lit("wd_mem", state, 3);
      end
      cyc(1, 0, 0); lit("wd_state", state, 6); lit("wd_trap", trap, 1);
      cyc(0, 0, 0);

      // ready on the timeout cycle completes the access
      cyc(1, 1, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0);
      cyc(1, 1, 0); lit("wd_edge_mem", state, 3);
      cyc(1, 1, 0); lit("wd_edge_wb", state, 4); lit("wd_edge_trap", trap, 0);
      cyc(1, 1, 0); lit("wd_edge_ret", instret, 1);

      // reset during a stalled MEM access
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(1, 0, 0); lit("rm_mem", state, 3); lit("rm_req", mem_req, 1);
      cyc(0, 0, 0); lit("rm_req_low", mem_req, 0); lit("rm_irw_low", ir_write, 0);
      cyc(1, 1, 0); lit("rm_state", state, 0); lit("rm_instret", instret, 0);
      lit("rm_fetch", mem_req, 1);
      cyc(0, 0, 0);

      // 17 retires wrap the 4-bit counter to 1
      cur_op = 7'b0110011;
      for (int i = 0; i < 17 * 4; i++) cyc(1, 1, 0);
      cyc(1, 1, 0); lit("wrap_state", state, 0); lit("wrap_instret", instret, 1);

      // random instruction streams
      stuck = 0;
      for (int n = 0; n < 4000; n++) begin
         if (ms == 0) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 82)      cur_op = optab[$urandom_range(0, 8)];
            else if (r < 88) cur_op = 7'b1110011;
            else             cur_op = 7'($urandom);
            cur_f3 = 3'($urandom);
         end
         stuck = (ms >= 5) ? stuck + 1 : 0;
         rn  = !(stuck > 4 || $urandom_range(0, 199) == 0);
         rdy = ($urandom_range(0, 9) < 6);
         cyc(rn, rdy, 1'($urandom));
      end

      @(negedge clk); #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
